coax_tx_feeder: RTL and testbench

- Drains the transmit-direction coax_buffer and presents 10-bit coax words to the coax transmitter as a valid/ready stream.
- Groups words into frames:
  - A frame starts on a host start pulse, or optionally when the buffer reaches almost-full.
  - A frame ends when the buffer runs dry or a maximum length is reached.
- Hides the buffer's one-cycle read latency with a two-entry prefetch, so back-to-back accepts see no bubbles.

---
 rtl/coax_tx_feeder.sv | 144 ++++++++++++++
 tb/tb_coax_tx_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : coax_tx_feeder
// Purpose  : Drains the transmit coax_buffer into framed valid/ready coax words
//            through a two-entry prefetch queue (head register plus skid).
// Revision : 1.0 - initial release
// ============================================================================
module coax_tx_feeder #(
    parameter int COUNT_WIDTH = 16,
    parameter int MAX_WORDS   = 1024,
    parameter int AUTO_START  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             buf_read_data,
    output logic                   buf_read_strobe,
    input  logic                   buf_empty,
    input  logic                   buf_almost_full,
    input  logic                   start,
    output logic [9:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   active,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] word_count
);

    localparam logic [COUNT_WIDTH-1:0] c_max_words = COUNT_WIDTH'(MAX_WORDS);
    localparam logic [COUNT_WIDTH-1:0] c_one       = COUNT_WIDTH'(1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              occ_q, occ_d;
    logic                    inflight_q, inflight_d;
    logic [9:0]              head_q, head_d;
    logic [9:0]              skid_q, skid_d;
    logic                    end_seen_q, end_seen_d;
    logic [COUNT_WIDTH-1:0]  reads_q, reads_d;
    logic [COUNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic                    frame_done_q, frame_done_d;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_start;
    logic                    w_read;
    logic [1:0]              w_occ_acc;

    always_comb begin
        w_accept  = (occ_q != 2'd0) && tx_ready;
        // A word in flight would follow the head, so the head cannot be last yet.
        w_last    = (occ_q == 2'd1) && end_seen_q && !inflight_q;
        w_start   = (start || ((AUTO_START != 0) && buf_almost_full)) && !buf_empty;
        w_occ_acc = occ_q - {1'b0, w_accept};
        w_read    = (state_q == STREAM) && !end_seen_q && !buf_empty &&
                    ((w_occ_acc + {1'b0, inflight_q}) < 2'd2);

        state_d      = state_q;
        head_d       = head_q;
        skid_d       = skid_q;
        end_seen_d   = end_seen_q;
        word_count_d = word_count_q;
        frame_done_d = 1'b0;
        inflight_d   = w_read;
        reads_d      = reads_q + {{(COUNT_WIDTH-1){1'b0}}, w_read};
        occ_d        = w_occ_acc;

        if (w_accept && (occ_q == 2'd2)) begin
            head_d = skid_q;
        end
        if (inflight_q) begin
            if (w_occ_acc == 2'd0) begin
                head_d = buf_read_data;
            end else begin
                skid_d = buf_read_data;
            end
            occ_d = w_occ_acc + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (w_start) begin
                    state_d      = STREAM;
                    word_count_d = '0;
                    reads_d      = '0;
                    end_seen_d   = 1'b0;
                end
            end
            STREAM: begin
                if (w_accept && (word_count_q != '1)) begin
                    word_count_d = word_count_q + c_one;
                end
                // End check looks at this cycle's post-update queue and read state.
                end_seen_d = end_seen_q ||
                             (buf_empty && !inflight_d && (occ_d <= 2'd1)) ||
                             (reads_d == c_max_words);
                if (w_accept && w_last) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    end_seen_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            head_q       <= '0;
            skid_q       <= '0;
            end_seen_q   <= 1'b0;
            reads_q      <= '0;
            word_count_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
            end_seen_q   <= end_seen_d;
            reads_q      <= reads_d;
            word_count_q <= word_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign buf_read_strobe = w_read;
    assign tx_data         = head_q;
    assign tx_valid        = (occ_q != 2'd0);
    assign tx_last         = w_last;
    assign active          = (state_q == STREAM);
    assign frame_done      = frame_done_q;
    assign word_count      = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_coax_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_coax_tx_feeder
// Purpose  : Directed bench for coax_tx_feeder with a buffer model and a
//            frame scoreboard of expected words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coax_tx_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  buf_read_data;
    logic        buf_read_strobe;
    logic        buf_empty;
    logic        buf_almost_full;
    logic        start;
    logic [9:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        active;
    logic        frame_done;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    coax_tx_feeder #(
        .COUNT_WIDTH (16),
        .MAX_WORDS   (4),
        .AUTO_START  (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .buf_read_data   (buf_read_data),
        .buf_read_strobe (buf_read_strobe),
        .buf_empty       (buf_empty),
        .buf_almost_full (buf_almost_full),
        .start           (start),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_last         (tx_last),
        .active          (active),
        .frame_done      (frame_done),
        .word_count      (word_count)
    );

    typedef struct {
        logic [9:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] fifo[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_strobe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int base, input int n);
        for (int i = 0; i < n; i++) fifo.push_back(10'(base + i));
        buf_empty = 1'b0;
    endtask

    task automatic expect_frame(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = 10'(base + i);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick(1);
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        check({"frame_done_seen_", name}, got, 1);
        check({"scoreboard_drained_", name}, exp_q.size(), 0);
    endtask

    // Buffer model: a strobe seen before the edge pops one word, visible after it.
    logic strobe_s = 1'b0;
    always @(negedge clk) strobe_s = buf_read_strobe;
    always @(posedge clk) begin
        #1;
        if (strobe_s && (fifo.size() > 0)) buf_read_data = fifo.pop_front();
        buf_empty = (fifo.size() == 0);
    end

    logic       prev_stall = 1'b0;
    logic [9:0] prev_data  = '0;
    logic       prev_last  = 1'b0;
    logic       done_exp   = 1'b0;
    logic       pend_wc    = 1'b0;
    int         pend_wc_val = 0;
    int         acc_in_frame = 0;
    exp_t       e_cur;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall   = 1'b0;
            prev_last    = 1'b0;
            done_exp     = 1'b0;
            pend_wc      = 1'b0;
            acc_in_frame = 0;
        end else begin
            if (buf_read_strobe) begin
                n_strobe++;
                check("no_read_when_empty", buf_empty, 0);
            end
            check("frame_done", frame_done, done_exp);
            if (pend_wc) check("word_count", word_count, pend_wc_val);
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
                if (prev_last) check("stall_last", tx_last, 1);
            end
            done_exp = 1'b0;
            pend_wc  = 1'b0;
            if (tx_valid && tx_ready) begin
                acc_in_frame++;
                pend_wc     = 1'b1;
                pend_wc_val = acc_in_frame;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", tx_data);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("tx_data", tx_data, e_cur.data);
                    check("tx_last", tx_last, e_cur.last);
                    if (e_cur.last) begin
                        done_exp     = 1'b1;
                        acc_in_frame = 0;
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        bit done;
        reset           = 1'b1;
        start           = 1'b0;
        tx_ready        = 1'b0;
        buf_almost_full = 1'b0;
        buf_empty       = 1'b1;
        buf_read_data   = '0;
        tick(3);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_active", active, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_word_count", word_count, 0);
        check("rst_strobe", buf_read_strobe, 0);
        reset = 1'b0;
        tick(1);

        // Single frame and start latency.
        n_strobe = 0;
        push_words(10'h101, 3);
        expect_frame(10'h101, 3);
        tick(2);
        check("idle_no_read", n_strobe, 0);
        check("idle_inactive", active, 0);
        tx_ready = 1'b1;
        pulse_start();
        check("t1_active", active, 1);
        check("t1_valid_c0", tx_valid, 0);
        tick(1);
        check("t1_valid_c1", tx_valid, 0);
        tick(1);
        check("t1_valid_c2", tx_valid, 1);
        check("t1_data0", tx_data, 10'h101);
        tick(1);
        check("t1_data1", tx_data, 10'h102);
        check("t1_last1", tx_last, 0);
        tick(1);
        check("t1_data2", tx_data, 10'h103);
        check("t1_last2", tx_last, 1);
        tick(1);
        check("t1_frame_done", frame_done, 1);
        check("t1_active_low", active, 0);
        check("t1_word_count", word_count, 3);
        check("t1_valid_low", tx_valid, 0);
        check("t1_strobes", n_strobe, 3);
        tick(1);
        check("t1_done_pulse", frame_done, 0);

        // Backpressure.
        n_strobe = 0;
        push_words(10'h201, 4);
        expect_frame(10'h201, 4);
        start = 1'b1;
        done  = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            tx_ready = pat[c % 4];
            tick(1);
            start = 1'b0;
            if (frame_done) done = 1'b1;
        end
        check("t2_frame_done_seen", done, 1);
        check("t2_strobes", n_strobe, 4);
        check("t2_word_count", word_count, 4);
        check("t2_drained", exp_q.size(), 0);
        tx_ready = 1'b1;

        // Frame cap at MAX_WORDS, remainder as a second frame.
        n_strobe = 0;
        push_words(10'h301, 6);
        expect_frame(10'h301, 4);
        pulse_start();
        wait_done("t3a");
        check("t3_word_count_a", word_count, 4);
        check("t3_strobes_a", n_strobe, 4);
        check("t3_left_in_buf", fifo.size(), 2);
        tick(3);
        check("t3_no_restart", active, 0);
        n_strobe = 0;
        expect_frame(10'h305, 2);
        pulse_start();
        wait_done("t3b");
        check("t3_word_count_b", word_count, 2);
        check("t3_strobes_b", n_strobe, 2);

        // Start on empty buffer is ignored; almost_full auto-starts.
        n_strobe = 0;
        pulse_start();
        tick(3);
        check("t4_empty_start", active, 0);
        check("t4_empty_strobes", n_strobe, 0);
        push_words(10'h401, 2);
        tick(2);
        check("t4_no_auto_yet", active, 0);
        expect_frame(10'h401, 2);
        buf_almost_full = 1'b1;
        tick(1);
        buf_almost_full = 1'b0;
        check("t4_auto_active", active, 1);
        wait_done("t4");
        check("t4_word_count", word_count, 2);

        // Late refill after end_seen stays out of the frame.
        n_strobe = 0;
        push_words(10'h501, 2);
        expect_frame(10'h501, 2);
        tx_ready = 1'b0;
        pulse_start();
        tick(4);
        check("t5_head", tx_data, 10'h501);
        check("t5_head_not_last", tx_last, 0);
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        check("t5_last_data", tx_data, 10'h502);
        check("t5_last_flag", tx_last, 1);
        push_words(10'h503, 2);
        tick(3);
        check("t5_hold_last", tx_last, 1);
        check("t5_hold_data", tx_data, 10'h502);
        check("t5_no_late_read", n_strobe, 2);
        tx_ready = 1'b1;
        wait_done("t5a");
        check("t5_word_count", word_count, 2);
        check("t5_refill_kept", fifo.size(), 2);
        expect_frame(10'h503, 2);
        pulse_start();
        wait_done("t5b");

        // Reset mid-frame after two accepted words.
        push_words(10'h601, 5);
        expect_frame(10'h601, 5);
        pulse_start();
        tick(4);
        check("t6_head", tx_data, 10'h603);
        check("t6_count_before", word_count, 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        fifo.delete();
        buf_empty = 1'b1;
        check("t6_valid", tx_valid, 0);
        check("t6_last", tx_last, 0);
        check("t6_data", tx_data, 0);
        check("t6_active", active, 0);
        check("t6_frame_done", frame_done, 0);
        check("t6_word_count", word_count, 0);
        tick(4);
        check("t6_still_idle", active, 0);
        push_words(10'h701, 1);
        expect_frame(10'h701, 1);
        pulse_start();
        wait_done("t6_after");
        check("t6_single_count", word_count, 1);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
